// File: rtl/rect_rasterizer_if.sv
// Pixel-write stream from the rasterizer to the frame-buffer writer.
interface rect_rasterizer_if #(
    parameter int unsigned X_W     = 9,
    parameter int unsigned Y_W     = 8,
    parameter int unsigned COLOR_W = 3
);
    logic               pix_valid;
    logic               pix_ready;
    logic [X_W-1:0]     x_stream;
    logic [Y_W-1:0]     y_stream;
    logic [COLOR_W-1:0] color_stream;

    modport master (
        output pix_valid, x_stream, y_stream, color_stream,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, x_stream, y_stream, color_stream,
        output pix_ready
    );
endinterface

// File: rtl/rect_rasterizer.sv
// Rectangle rasterizer: walks a rectangle row-major, clips to the screen and
// streams (x, y, colour) writes over a valid/ready handshake.
module rect_rasterizer #(
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240,
    parameter int unsigned X_W      = 9,
    parameter int unsigned Y_W      = 8,
    parameter int unsigned COLOR_W  = 3,
    parameter int unsigned BW_W     = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_W-1:0]     origin_x,
    input  logic [Y_W-1:0]     origin_y,
    input  logic [X_W-1:0]     width,
    input  logic [Y_W-1:0]     height,
    input  logic [COLOR_W-1:0] back_color,
    input  logic [BW_W-1:0]    border_w,
    input  logic [COLOR_W-1:0] border_color,
    output logic               busy,
    output logic               done,
    rect_rasterizer_if.master  pix
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    logic [1:0]         state, state_d;
    logic               busy_d, done_d;
    logic [X_W-1:0]     ox_q, ox_d, w_q, w_d, col, col_d;
    logic [Y_W-1:0]     oy_q, oy_d, h_q, h_d, row, row_d;
    logic [BW_W-1:0]    bw_q, bw_d;
    logic [COLOR_W-1:0] bc_q, bc_d, fc_q, fc_d;
    logic               valid_d;
    logic [X_W-1:0]     x_d;
    logic [Y_W-1:0]     y_d;
    logic [COLOR_W-1:0] c_d;
    logic               load, last_col, last_row, vis, on_border;
    logic [X_W:0]       px;
    logic [Y_W:0]       py;

    // Next-state, counter walk and next-pixel evaluation
    always_comb begin
        state_d  = state;
        busy_d   = busy;
        done_d   = 1'b0;
        ox_d     = ox_q;
        oy_d     = oy_q;
        w_d      = w_q;
        h_d      = h_q;
        bw_d     = bw_q;
        bc_d     = bc_q;
        fc_d     = fc_q;
        col_d    = col;
        row_d    = row;
        valid_d  = pix.pix_valid;
        x_d      = pix.x_stream;
        y_d      = pix.y_stream;
        c_d      = pix.color_stream;
        load     = 1'b0;
        last_col = (col == w_q - X_W'(1));
        last_row = (row == h_q - Y_W'(1));

        case (state)
            IDLE: begin
                // done qualifies start so a start coinciding with the pulse is dropped
                if (start && !done) begin
                    ox_d   = origin_x;
                    oy_d   = origin_y;
                    w_d    = width;
                    h_d    = height;
                    bw_d   = border_w;
                    bc_d   = border_color;
                    fc_d   = back_color;
                    busy_d = 1'b1;
                    if (width == '0 || height == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d = RUN;
                        col_d   = '0;
                        row_d   = '0;
                        load    = 1'b1;
                    end
                end
            end
            RUN: begin
                // clipped positions advance every cycle, visible ones on handshake
                if (!pix.pix_valid || pix.pix_ready) begin
                    if (last_col && last_row) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                    end else begin
                        load = 1'b1;
                        if (last_col) begin
                            col_d = '0;
                            row_d = row + Y_W'(1);
                        end else begin
                            col_d = col + X_W'(1);
                        end
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // widened sums so positions past the coordinate range still clip
        px        = {1'b0, ox_d} + {1'b0, col_d};
        py        = {1'b0, oy_d} + {1'b0, row_d};
        vis       = (px < SCR_W) && (py < SCR_H);
        on_border = (col_d < X_W'(bw_d)) || (col_d >= w_d - X_W'(bw_d)) ||
                    (row_d < Y_W'(bw_d)) || (row_d >= h_d - Y_W'(bw_d));

        if (load) begin
            valid_d = vis;
            if (vis) begin
                x_d = px[X_W-1:0];
                y_d = py[Y_W-1:0];
                c_d = on_border ? bc_d : fc_d;
            end
        end
    end

    // State, attribute and registered-output update
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            ox_q             <= '0;
            oy_q             <= '0;
            w_q              <= '0;
            h_q              <= '0;
            bw_q             <= '0;
            bc_q             <= '0;
            fc_q             <= '0;
            col              <= '0;
            row              <= '0;
            pix.pix_valid    <= 1'b0;
            pix.x_stream     <= '0;
            pix.y_stream     <= '0;
            pix.color_stream <= '0;
        end else begin
            state            <= state_d;
            busy             <= busy_d;
            done             <= done_d;
            ox_q             <= ox_d;
            oy_q             <= oy_d;
            w_q              <= w_d;
            h_q              <= h_d;
            bw_q             <= bw_d;
            bc_q             <= bc_d;
            fc_q             <= fc_d;
            col              <= col_d;
            row              <= row_d;
            pix.pix_valid    <= valid_d;
            pix.x_stream     <= x_d;
            pix.y_stream     <= y_d;
            pix.color_stream <= c_d;
        end
    end
endmodule

// File: tb/tb_rect_rasterizer.sv
// Scoreboard bench for rect_rasterizer.
`timescale 1ns/1ps
module tb_rect_rasterizer;
    localparam int unsigned X_W = 9;
    localparam int unsigned Y_W = 8;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned BW_W = 4;
    localparam int unsigned PW = X_W + Y_W + COLOR_W;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               start = 1'b0;
    logic [X_W-1:0]     origin_x = '0;
    logic [Y_W-1:0]     origin_y = '0;
    logic [X_W-1:0]     width = '0;
    logic [Y_W-1:0]     height = '0;
    logic [COLOR_W-1:0] back_color = '0;
    logic [BW_W-1:0]    border_w = '0;
    logic [COLOR_W-1:0] border_color = '0;
    logic               busy, done;

    rect_rasterizer_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) pix();

    rect_rasterizer dut (
        .clk(clk), .resetn(resetn), .start(start),
        .origin_x(origin_x), .origin_y(origin_y), .width(width), .height(height),
        .back_color(back_color), .border_w(border_w), .border_color(border_color),
        .busy(busy), .done(done), .pix(pix)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int hs_cnt = 0;
    logic [PW-1:0] sb[$];
    bit rdy_q[$];
    bit rdy_rand = 1'b0;
    logic stalled_prev = 1'b0;
    logic [PW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Downstream ready: scripted pattern first, then random or always-ready
    initial begin
        pix.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_q.size() > 0) pix.pix_ready = rdy_q.pop_front();
            else if (rdy_rand) pix.pix_ready = 1'($urandom_range(0, 1));
            else pix.pix_ready = 1'b1;
        end
    end

    // Monitor: pop and compare on each handshake, check stability across stalls
    always @(negedge clk) begin
        logic [PW-1:0] cur;
        logic [PW-1:0] exp;
        cur = {pix.x_stream, pix.y_stream, pix.color_stream};
        if (stalled_prev && resetn) begin
            chk("hold_valid", 32'(pix.pix_valid), 32'd1);
            chk("hold_data", 32'(cur), 32'(prev_data));
        end
        if (pix.pix_valid && pix.pix_ready) begin
            hs_cnt++;
            if (sb.size() > 0) exp = sb.pop_front();
            else exp = '1;
            chk("pixel", 32'(cur), 32'(exp));
        end
        stalled_prev = pix.pix_valid && !pix.pix_ready && resetn;
        prev_data = cur;
    end

    // Reference model: expected visible pixels in scan order
    task automatic push_rect(input int ox, input int oy, input int w, input int h,
                             input int bw, input int bc, input int fc, output int nvis);
        nvis = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int px = ox + c;
                int py = oy + r;
                bit brd = (c < bw) || (c >= w - bw) || (r < bw) || (r >= h - bw);
                if (px < 320 && py < 240) begin
                    sb.push_back({9'(px), 8'(py), 3'(brd ? bc : fc)});
                    nvis++;
                end
            end
        end
    endtask

    // One-cycle start; returns at the start of cycle 1 with inputs scrambled
    task automatic start_rect(input int ox, input int oy, input int w, input int h,
                              input int bw, input int bc, input int fc, output int nvis);
        @(posedge clk);
        #1;
        origin_x = X_W'(ox); origin_y = Y_W'(oy);
        width = X_W'(w); height = Y_W'(h);
        border_w = BW_W'(bw); border_color = COLOR_W'(bc); back_color = COLOR_W'(fc);
        start = 1'b1;
        push_rect(ox, oy, w, h, bw, bc, fc, nvis);
        @(posedge clk);
        #1;
        start = 1'b0;
        origin_x = X_W'($urandom); origin_y = Y_W'($urandom);
        width = X_W'($urandom); height = Y_W'($urandom);
        border_w = BW_W'($urandom); border_color = COLOR_W'($urandom);
        back_color = COLOR_W'($urandom);
    endtask

    task automatic wait_done(input int budget, output int done_cyc, output int busy_cyc,
                             output int inv_cyc);
        done_cyc = 0; busy_cyc = 0; inv_cyc = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (done) begin
                done_cyc = k;
                break;
            end
            if (busy) busy_cyc++;
            if (busy && !pix.pix_valid) inv_cyc++;
        end
        chk("done_seen", 32'(done_cyc != 0), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int nv, dc, bc, ic, base;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, dc, bcy, ic, base;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(pix.pix_valid), 32'd0);
        chk("rst_xyc", 32'({pix.x_stream, pix.y_stream, pix.color_stream}), 32'd0);
        @(posedge clk); #1; resetn = 1'b1;

        // 4x3 fully visible, no border
        base = hs_cnt;
        start_rect(10, 20, 4, 3, 0, 0, 5, nv);
        wait_done(200, dc, bcy, ic);
        chk("t1_done_cycle", 32'(dc), 32'd14);
        chk("t1_busy_cycles", 32'(bcy), 32'd13);
        chk("t1_handshakes", 32'(hs_cnt - base), 32'd12);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 5x5 with 1-pixel border
        base = hs_cnt;
        start_rect(0, 0, 5, 5, 1, 2, 7, nv);
        wait_done(200, dc, bcy, ic);
        chk("t2_done_cycle", 32'(dc), 32'd27);
        chk("t2_handshakes", 32'(hs_cnt - base), 32'd25);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // corner clipping on both axes
        base = hs_cnt;
        start_rect(316, 239, 8, 2, 0, 4, 1, nv);
        wait_done(200, dc, bcy, ic);
        chk("t3_handshakes", 32'(hs_cnt - base), 32'd4);
        chk("t3_invalid_busy", 32'(ic), 32'd13);
        chk("t3_done_cycle", 32'(dc), 32'd18);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // stalls: ready 1,0,0,1,1
        base = hs_cnt;
        start_rect(100, 100, 3, 1, 1, 6, 3, nv);
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        wait_done(200, dc, bcy, ic);
        chk("t4_handshakes", 32'(hs_cnt - base), 32'd3);
        chk("t4_done_cycle", 32'(dc), 32'd7);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // empty rectangle, start while busy and during done ignored
        base = hs_cnt;
        start_rect(5, 5, 0, 9, 0, 1, 1, nv);
        start = 1'b1; width = X_W'(4); height = Y_W'(1); origin_x = '0; origin_y = '0;
        @(negedge clk);
        chk("t5_busy_c1", 32'(busy), 32'd1);
        chk("t5_done_c1", 32'(done), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_done_c2", 32'(done), 32'd1);
        chk("t5_busy_c2", 32'(busy), 32'd0);
        @(posedge clk); #1; start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t5_idle_busy", 32'(busy), 32'd0);
            chk("t5_idle_valid", 32'(pix.pix_valid), 32'd0);
        end
        chk("t5_handshakes", 32'(hs_cnt - base), 32'd0);

        // reset in the middle of a 10x10, then restart
        base = hs_cnt;
        start_rect(50, 60, 10, 10, 2, 4, 1, nv);
        repeat (6) @(posedge clk);
        #2; resetn = 1'b0;
        chk("t6_hs_before_rst", 32'(hs_cnt - base), 32'd6);
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(pix.pix_valid), 32'd0);
        chk("t6_rst_xyc", 32'({pix.x_stream, pix.y_stream, pix.color_stream}), 32'd0);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1; resetn = 1'b1;
        base = hs_cnt;
        start_rect(50, 60, 2, 1, 0, 4, 1, nv);
        wait_done(200, dc, bcy, ic);
        chk("t6_restart_hs", 32'(hs_cnt - base), 32'd2);
        chk("t6_restart_done", 32'(dc), 32'd4);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        // random rectangles with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            base = hs_cnt;
            start_rect(int'($urandom_range(0, 330)), int'($urandom_range(0, 245)),
                       int'($urandom_range(1, 12)), int'($urandom_range(1, 8)),
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), nv);
            wait_done(2000, dc, bcy, ic);
            chk("rnd_handshakes", 32'(hs_cnt - base), 32'(nv));
            chk("rnd_sb_empty", 32'(sb.size()), 32'd0);
        end
        rdy_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
